// File: rtl/mem_test_sequencer.sv
// mem_test_sequencer
//   Preload / run / check engine for the mips_32 datapath bring-up.
//   Holds the CPU in reset while writing a preload table into data memory,
//   lets the CPU run for RUN_CYCLES clocks, freezes it again, then reads
//   back NUM_CHECKS result words and scores them against an expected table.
//
//   Optional feature macro: MEM_TEST_SCORE_WEIGHT_EN
//     defined   : score accumulates exp_weight (half-points) per passing check
//     undefined : exp_weight is ignored, score = 2*pass_count
//
// Ports
//   clk             system clock
//   reset           asynchronous active-low reset
//   start           one-cycle pulse, starts a sequence when not busy
//   cpu_hold        1 = keep CPU in reset / frozen
//   mem_we          data-memory write enable
//   mem_addr        data-memory word address
//   mem_wdata       data-memory write data
//   mem_rdata       data-memory read data, valid one cycle after mem_addr
//   pre_idx         preload table index
//   pre_data        preload word for pre_idx (combinational)
//   exp_idx         expected table index
//   exp_data        expected word for exp_idx (combinational)
//   exp_weight      weight of check exp_idx in half-points
//   busy            sequence in progress
//   done            sequence finished, held until next start
//   pass_count      checks matched (saturating)
//   fail_count      checks mismatched (saturating)
//   score           accumulated score in half-points (saturating)
//   first_fail_addr address of first mismatch, all-ones if none
module mem_test_sequencer #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int NUM_PRELOAD = 10,
   parameter int CHECK_BASE  = 11,
   parameter int NUM_CHECKS  = 55,
   parameter int RUN_CYCLES  = 134
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  cpu_hold,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [((NUM_PRELOAD > 1) ? $clog2(NUM_PRELOAD) : 1)-1:0] pre_idx,
   input  logic [DATA_WIDTH-1:0] pre_data,
   output logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] exp_idx,
   input  logic [DATA_WIDTH-1:0] exp_data,
   input  logic [3:0]            exp_weight,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            pass_count,
   output logic [7:0]            fail_count,
   output logic [11:0]           score,
   output logic [ADDR_WIDTH-1:0] first_fail_addr
);

   localparam int PW = (NUM_PRELOAD > 1) ? $clog2(NUM_PRELOAD) : 1;
   localparam int EW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
   localparam int RW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(NUM_PRELOAD - 1);
   localparam logic [EW-1:0] EXP_LAST = EW'(NUM_CHECKS - 1);
   localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);

   // Elaboration-time parameter sanity
   if (CHECK_BASE + NUM_CHECKS - 1 >= (64'(1) << ADDR_WIDTH)) begin : g_bad_range
      $error("mem_test_sequencer: CHECK_BASE+NUM_CHECKS-1 exceeds address space");
   end
   if (RUN_CYCLES < 1) begin : g_bad_run
      $error("mem_test_sequencer: RUN_CYCLES must be >= 1");
   end
   if (NUM_PRELOAD < 1 || NUM_CHECKS < 1) begin : g_bad_count
      $error("mem_test_sequencer: NUM_PRELOAD and NUM_CHECKS must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRELOAD,
      S_RUN,
      S_CHK_ADDR,
      S_CHK_CMP,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         run_cnt;
   logic [ADDR_WIDTH-1:0] chk_addr;
   logic                  match;
   logic                  clear;

   assign chk_addr = ADDR_WIDTH'(CHECK_BASE) + ADDR_WIDTH'(exp_idx);
   assign match    = (mem_rdata == exp_data);
   assign clear    = start && (state_q == S_IDLE || state_q == S_DONE);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_d   = state_q;
      cpu_hold  = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_PRELOAD;
         end
         S_PRELOAD: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ADDR_WIDTH'(pre_idx);
            mem_wdata = pre_data;
            if (pre_idx == PRE_LAST) state_d = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            cpu_hold = 1'b0;
            if (run_cnt == RUN_LAST) state_d = S_CHK_ADDR;
         end
         S_CHK_ADDR: begin
            busy     = 1'b1;
            mem_addr = chk_addr;
            state_d  = S_CHK_CMP;
         end
         S_CHK_CMP: begin
            // address held so the registered read stays aligned with exp_idx
            busy     = 1'b1;
            mem_addr = chk_addr;
            state_d  = (exp_idx == EXP_LAST) ? S_DONE : S_CHK_ADDR;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_d = S_PRELOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Indices, run timer, counters, first-fail capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_idx         <= '0;
         exp_idx         <= '0;
         run_cnt         <= '0;
         pass_count      <= '0;
         fail_count      <= '0;
         first_fail_addr <= '1;
      end else if (clear) begin
         pre_idx         <= '0;
         exp_idx         <= '0;
         run_cnt         <= '0;
         pass_count      <= '0;
         fail_count      <= '0;
         first_fail_addr <= '1;
      end else begin
         case (state_q)
            S_PRELOAD: pre_idx <= (pre_idx == PRE_LAST) ? '0 : pre_idx + 1'b1;
            S_RUN:     run_cnt <= (run_cnt == RUN_LAST) ? '0 : run_cnt + 1'b1;
            S_CHK_CMP: begin
               if (match) begin
                  if (pass_count != '1) pass_count <= pass_count + 1'b1;
               end else begin
                  if (fail_count != '1) fail_count <= fail_count + 1'b1;
                  if (first_fail_addr == '1) first_fail_addr <= chk_addr;
               end
               exp_idx <= (exp_idx == EXP_LAST) ? '0 : exp_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_TEST_SCORE_WEIGHT_EN
   logic [11:0] score_q;
   logic [12:0] score_sum;

   assign score_sum = {1'b0, score_q} + 13'(exp_weight);
   assign score     = score_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         score_q <= '0;
      end else if (clear) begin
         score_q <= '0;
      end else if (state_q == S_CHK_CMP && match) begin
         score_q <= score_sum[12] ? '1 : score_sum[11:0];
      end
   end
`else
   // One point (two half-points) per pass; pass_count saturates at 255 so this fits
   logic unused_weight;
   assign unused_weight = ^exp_weight;
   assign score         = {3'b000, pass_count, 1'b0};
`endif

endmodule

// File: tb/tb_mem_test_sequencer.sv
module tb_mem_test_sequencer;

   localparam int NP    = 10;
   localparam int CB    = 11;
   localparam int NC    = 55;
   localparam int RC    = 134;
   localparam int LAT_A = 1 + NP + RC + 2 * NC;
   localparam int NPB   = 2;
   localparam int RCB   = 3;
   localparam int NCB   = 2;
   localparam int LAT_B = 1 + NPB + RCB + 2 * NCB;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [7:0]  pass;
      logic [7:0]  fail;
      logic [11:0] score;
      logic [7:0]  ffa;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // DUT A (default parameters)
   logic        start_a, hold_a, we_a, busy_a, done_a;
   logic [7:0]  addr_a, pass_a, fail_a, ffa_a;
   logic [31:0] wdata_a, rdata_a, pre_data_a, exp_data_a;
   logic [3:0]  pre_idx_a, weight_a;
   logic [5:0]  exp_idx_a;
   logic [11:0] score_a;

   // DUT B (short sequence)
   logic        start_b, hold_b, we_b, busy_b, done_b;
   logic [7:0]  addr_b, pass_b, fail_b, ffa_b;
   logic [31:0] wdata_b, rdata_b, pre_data_b, exp_data_b;
   logic [0:0]  pre_idx_b, exp_idx_b;
   logic [3:0]  weight_b;
   logic [11:0] score_b;

   logic [31:0] pre_tbl [16] = '{32'h00000005, 32'h0fdf6e91, 32'h12345678, 32'h89abcdef,
                                 32'h0badf00d, 32'h3c3c3c3c, 32'hdeadbeef, 32'h00c0ffee,
                                 32'h7f7f0001, 32'hd18fa600, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0};
   logic [31:0] ram_a [256];
   logic [31:0] ram_b [256];
   logic        force_zero [256];
   int          cpu_k = 0;

   wr_t  wq[$];
   res_t rq_a[$];
   res_t rq_b[$];

   int npass = 0;
   int nfail = 0;
   int nchk  = 0;

   function automatic logic [31:0] golden(input int k);
      return (pre_tbl[k % NP] + 32'(k) * 32'h9E3779B9) | 32'h1;
   endfunction

   function automatic logic [31:0] bval(input logic [7:0] a);
      return {4{a}};
   endfunction

   mem_test_sequencer dut_a (
      .clk(clk), .reset(rst_n), .start(start_a), .cpu_hold(hold_a),
      .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
      .pre_idx(pre_idx_a), .pre_data(pre_data_a), .exp_idx(exp_idx_a),
      .exp_data(exp_data_a), .exp_weight(weight_a), .busy(busy_a), .done(done_a),
      .pass_count(pass_a), .fail_count(fail_a), .score(score_a),
      .first_fail_addr(ffa_a)
   );

   mem_test_sequencer #(.NUM_PRELOAD(NPB), .RUN_CYCLES(RCB), .NUM_CHECKS(NCB)) dut_b (
      .clk(clk), .reset(rst_n), .start(start_b), .cpu_hold(hold_b),
      .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
      .pre_idx(pre_idx_b), .pre_data(pre_data_b), .exp_idx(exp_idx_b),
      .exp_data(exp_data_b), .exp_weight(weight_b), .busy(busy_b), .done(done_b),
      .pass_count(pass_b), .fail_count(fail_b), .score(score_b),
      .first_fail_addr(ffa_b)
   );

   // Tables
   assign pre_data_a = pre_tbl[pre_idx_a];
   assign exp_data_a = golden(int'(exp_idx_a));
   assign weight_a   = (exp_idx_a < 6'd45) ? 4'd2 : 4'd5;
   assign pre_data_b = pre_tbl[4'(pre_idx_b)];
   assign exp_data_b = bval(8'(CB) + 8'(exp_idx_b));
   assign weight_b   = 4'd3;

   // Memory A with a stand-in CPU that derives results from preloaded words
   always @(posedge clk) begin
      if (we_a) ram_a[addr_a] <= wdata_a;
      rdata_a <= force_zero[addr_a] ? 32'h0 : ram_a[addr_a];
      if (hold_a) begin
         cpu_k <= 0;
      end else if (cpu_k < NC) begin
         ram_a[CB + cpu_k] <= (ram_a[cpu_k % NP] + 32'(cpu_k) * 32'h9E3779B9) | 32'h1;
         cpu_k <= cpu_k + 1;
      end
   end

   // Memory B: result region returns fixed pattern
   always @(posedge clk) begin
      if (we_b) ram_b[addr_b] <= wdata_b;
      rdata_b <= (addr_b >= 8'(CB)) ? bval(addr_b) : ram_b[addr_b];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Preload-write scoreboard for DUT A
   always @(negedge clk) begin
      if (rst_n && we_a) begin
         wr_t e;
         check("wr_queue_nonempty", 32'(wq.size() != 0), 32'd1);
         if (wq.size() != 0) begin
            e = wq.pop_front();
            check("wr_addr", 32'(addr_a), 32'(e.addr));
            check("wr_data", wdata_a, e.data);
         end
      end
   end

   function automatic res_t model_a();
      res_t r;
      int p = 0;
      int f = 0;
      int s = 0;
      logic [7:0] ffa = 8'hFF;
      for (int i = 0; i < NC; i++) begin
         if (force_zero[CB + i] && golden(i) != 32'h0) begin
            f++;
            if (ffa == 8'hFF) ffa = 8'(CB + i);
         end else begin
            p++;
            s += (i < 45) ? 2 : 5;
         end
      end
`ifndef MEM_TEST_SCORE_WEIGHT_EN
      s = 2 * p;
`endif
      r.pass  = 8'(p);
      r.fail  = 8'(f);
      r.score = 12'(s);
      r.ffa   = ffa;
      return r;
   endfunction

   task automatic run_a(input string tag);
      int   cyc;
      res_t r;
      for (int i = 0; i < NP; i++) wq.push_back('{addr: 8'(i), data: pre_tbl[i]});
      rq_a.push_back(model_a());
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      cyc = 1;
      check({tag, "_busy_start"}, 32'(busy_a), 32'd1);
      check({tag, "_done_cleared"}, 32'(done_a), 32'd0);
      while (!done_a && cyc < 2000) begin
         @(posedge clk);
         #1 cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(LAT_A));
      check({tag, "_done"}, 32'(done_a), 32'd1);
      if (rq_a.size() != 0) begin
         r = rq_a.pop_front();
         check({tag, "_pass"}, 32'(pass_a), 32'(r.pass));
         check({tag, "_fail"}, 32'(fail_a), 32'(r.fail));
         check({tag, "_score"}, 32'(score_a), 32'(r.score));
         check({tag, "_ffa"}, 32'(ffa_a), 32'(r.ffa));
      end
      check({tag, "_hold_end"}, 32'(hold_a), 32'd1);
      check({tag, "_busy_end"}, 32'(busy_a), 32'd0);
      check({tag, "_writes_left"}, 32'(wq.size()), 32'd0);
   endtask

   initial begin
      int   cyc;
      int   holdlow;
      res_t rb;

      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < 256; i++) force_zero[i] = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_hold",  32'(hold_a), 32'd1);
      check("rst_we",    32'(we_a), 32'd0);
      check("rst_addr",  32'(addr_a), 32'd0);
      check("rst_wdata", wdata_a, 32'd0);
      check("rst_busy",  32'(busy_a), 32'd0);
      check("rst_done",  32'(done_a), 32'd0);
      check("rst_pass",  32'(pass_a), 32'd0);
      check("rst_score", 32'(score_a), 32'd0);
      check("rst_ffa",   32'(ffa_a), 32'hFF);
      check("rst_exp_idx", 32'(exp_idx_a), 32'd0);
      check("rst_hold_b",  32'(hold_b), 32'd1);
      @(negedge clk) rst_n = 1'b1;

      // Abort during preload with asynchronous reset
      for (int i = 0; i < NP; i++) wq.push_back('{addr: 8'(i), data: pre_tbl[i]});
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      for (int i = 0; i < 50 && pre_idx_a != 4'd4; i++) @(negedge clk);
      check("abort_reach_idx4", 32'(pre_idx_a), 32'd4);
      check("abort_we_before", 32'(we_a), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_hold",    32'(hold_a), 32'd1);
      check("abort_we",      32'(we_a), 32'd0);
      check("abort_busy",    32'(busy_a), 32'd0);
      check("abort_pass",    32'(pass_a), 32'd0);
      check("abort_fail",    32'(fail_a), 32'd0);
      check("abort_pre_idx", 32'(pre_idx_a), 32'd0);
      check("abort_ffa",     32'(ffa_a), 32'hFF);
      wq.delete();
      @(negedge clk) rst_n = 1'b1;

      // Full sequences: clean, one forced mismatch, two forced mismatches
      run_a("clean");
      force_zero[14] = 1'b1;
      run_a("f14");
      force_zero[14] = 1'b0;
      force_zero[20] = 1'b1;
      force_zero[30] = 1'b1;
      run_a("f20_30");
      force_zero[20] = 1'b0;
      force_zero[30] = 1'b0;

      // Short sequence: exact latency, run window, start ignored while busy
      rb.pass = 8'd2;
      rb.fail = 8'd0;
`ifdef MEM_TEST_SCORE_WEIGHT_EN
      rb.score = 12'd6;
`else
      rb.score = 12'd4;
`endif
      rb.ffa = 8'hFF;
      rq_b.push_back(rb);
      @(negedge clk) start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      cyc     = 1;
      holdlow = 0;
      check("b_busy_start", 32'(busy_b), 32'd1);
      while (!done_b && cyc < 100) begin
         start_b = (cyc == 3 || cyc == 6) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1 cyc++;
         if (!hold_b) holdlow++;
      end
      start_b = 1'b0;
      check("b_latency", 32'(cyc), 32'(LAT_B));
      check("b_hold_low_cycles", 32'(holdlow), 32'(RCB));
      if (rq_b.size() != 0) begin
         rb = rq_b.pop_front();
         check("b_pass",  32'(pass_b), 32'(rb.pass));
         check("b_fail",  32'(fail_b), 32'(rb.fail));
         check("b_score", 32'(score_b), 32'(rb.score));
         check("b_ffa",   32'(ffa_b), 32'(rb.ffa));
      end
      repeat (3) @(posedge clk);
      #1 check("b_done_held", 32'(done_b), 32'd1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
